multicycle_controller: RTL and testbench

Multi-cycle sequencing controller for the RV32I R/I-type datapath. It walks each instruction through FETCH, DECODE, EXECUTE, MEM and WB using a finite state machine. It drives instruction/data memory request-acknowledge handshakes, the IR and PC write strobes, ALU operation select, operand-B mux select and register-file write enable. It sits between the memories and the existing ALU/register-file datapath and replaces purely combinational decode with registered, stage-timed control.

---
 rtl/ctrl_pkg.sv | 69 ++++++
 rtl/instr_decoder.sv | 82 ++++++++
 rtl/multicycle_controller.sv | 165 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the RV32I multi-cycle sequencing controller:
//   alu_op_e      - 5-bit ALU operation codes driven to the datapath ALU
//   ctrl_state_e  - controller FSM states
//   OPC_*         - major opcodes accepted by the controller
//   F7_*          - funct7 values distinguishing base / alternate operations
//   F3_*          - funct3 values used by the ALU classification
//   base_alu_op   - funct3 -> ALU op for the base (funct7 = 0) encodings
// ----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } ctrl_state_e;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    function automatic alu_op_e base_alu_op(input logic [2:0] funct3);
        alu_op_e op;
        op = ALU_ADD;
        case (funct3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// ----------------------------------------------------------------------------
// instr_decoder
// Combinational classification of an RV32I R/I-ALU/load/store instruction.
// Ports:
//   opcode   in  7  instruction[6:0]
//   funct3   in  3  instruction[14:12]
//   funct7   in  7  instruction[31:25]
//   alu_op   out    ALU operation (add for loads/stores)
//   sel_b    out 1  operand B: 0 = rs2, 1 = immediate
//   wb_sel   out 1  write-back source: 0 = ALU, 1 = load data
//   is_load  out 1  instruction is a load
//   is_store out 1  instruction is a store
//   mem_size out 3  access size (funct3) for loads/stores
//   illegal  out 1  encoding not supported by the controller
// ----------------------------------------------------------------------------
module instr_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output alu_op_e    alu_op,
    output logic       sel_b,
    output logic       wb_sel,
    output logic       is_load,
    output logic       is_store,
    output logic [2:0] mem_size,
    output logic       illegal
);

    always_comb begin
        alu_op   = ALU_ADD;
        sel_b    = 1'b0;
        wb_sel   = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        mem_size = funct3;
        illegal  = 1'b0;

        case (opcode)
            OPC_R: begin
                if (funct7 == F7_BASE) begin
                    alu_op = base_alu_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    alu_op = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OPC_I_ALU: begin
                sel_b = 1'b1;
                // Only the shift-immediates carry a funct7 field; elsewhere
                // those bits belong to the immediate and are not checked.
                case (funct3)
                    F3_SLL: begin
                        if (funct7 == F7_BASE) alu_op = ALU_SLL;
                        else                   illegal = 1'b1;
                    end
                    F3_SR: begin
                        if (funct7 == F7_BASE)     alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_op = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    default: alu_op = base_alu_op(funct3);
                endcase
            end
            OPC_LOAD: begin
                sel_b   = 1'b1;
                wb_sel  = 1'b1;
                is_load = 1'b1;
            end
            OPC_STORE: begin
                sel_b    = 1'b1;
                is_store = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// ----------------------------------------------------------------------------
// multicycle_controller
// Stage-timed control FSM (FETCH, DECODE, EXECUTE, MEM, WB, TRAP) for the
// RV32I R/I-type datapath.
// Optional feature macro: CTRL_RETIRE_CNT_EN adds the retired_count port.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   instruction           IR contents, valid from DECODE onward
//   imem_req / imem_ack   instruction fetch handshake
//   ir_write_enable       IR load, on the fetch ack cycle
//   dmem_req / dmem_ack   data access handshake
//   dmem_we, dmem_size    store flag and funct3 size, valid while dmem_req
//   alu_op, sel_b, wb_sel datapath controls, registered in DECODE
//   regfile_write_enable  one-cycle pulse in WB
//   pc_write_enable       one-cycle pulse at retirement
//   illegal_instr         high while in TRAP (sticky until rst)
//   retired_count         retired-instruction counter (macro only)
// ----------------------------------------------------------------------------
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = 32,
    parameter int unsigned ALU_OP_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INSTR_WIDTH-1:0]  instruction,
    output logic                    imem_req,
    input  logic                    imem_ack,
    output logic                    ir_write_enable,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [2:0]              dmem_size,
    input  logic                    dmem_ack,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    sel_b,
    output logic                    wb_sel,
    output logic                    regfile_write_enable,
    output logic                    pc_write_enable,
    output logic                    illegal_instr
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [31:0]             retired_count
`endif
);

    ctrl_state_e state;
    ctrl_state_e next_state;

    alu_op_e    dec_alu_op;
    logic       dec_sel_b;
    logic       dec_wb_sel;
    logic       dec_is_load;
    logic       dec_is_store;
    logic [2:0] dec_mem_size;
    logic       dec_illegal;

    // Set in DECODE for loads and stores; steers EXECUTE towards MEM.
    logic       mem_op_q;

    // Register-specifier and immediate fields are consumed by the datapath.
    logic       unused_instr_bits;
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

    instr_decoder u_decoder (
        .opcode   (instruction[6:0]),
        .funct3   (instruction[14:12]),
        .funct7   (instruction[31:25]),
        .alu_op   (dec_alu_op),
        .sel_b    (dec_sel_b),
        .wb_sel   (dec_wb_sel),
        .is_load  (dec_is_load),
        .is_store (dec_is_store),
        .mem_size (dec_mem_size),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op    <= '0;
            sel_b     <= 1'b0;
            wb_sel    <= 1'b0;
            dmem_we   <= 1'b0;
            dmem_size <= '0;
            mem_op_q  <= 1'b0;
        end else if (state == DECODE) begin
            alu_op    <= ALU_OP_WIDTH'(dec_alu_op);
            sel_b     <= dec_sel_b;
            wb_sel    <= dec_wb_sel;
            dmem_we   <= dec_is_store;
            dmem_size <= dec_mem_size;
            mem_op_q  <= dec_is_load | dec_is_store;
        end
    end

    always_comb begin
        next_state           = state;
        imem_req             = 1'b0;
        ir_write_enable      = 1'b0;
        dmem_req             = 1'b0;
        regfile_write_enable = 1'b0;
        pc_write_enable      = 1'b0;

        case (state)
            FETCH: begin
                // Reset holds the state in FETCH; masking with rst keeps the
                // request low for the whole reset window.
                imem_req = ~rst;
                if (imem_ack) begin
                    ir_write_enable = ~rst;
                    next_state      = DECODE;
                end
            end
            DECODE: begin
                next_state = dec_illegal ? TRAP : EXECUTE;
            end
            EXECUTE: begin
                next_state = mem_op_q ? MEM : WB;
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (wb_sel) begin
                        next_state = WB;
                    end else begin
                        pc_write_enable = 1'b1;
                        next_state      = FETCH;
                    end
                end
            end
            WB: begin
                regfile_write_enable = 1'b1;
                pc_write_enable      = 1'b1;
                next_state           = FETCH;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
    end

    assign illegal_instr = (state == TRAP);

`ifdef CTRL_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_count <= '0;
        end else if (pc_write_enable) begin
            retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_controller
// Self-checking bench for multicycle_controller. The bench plays both
// memories; the reference model is a table of legal encodings plus the
// stage-sequence rules. Build with CTRL_RETIRE_CNT_EN to cover the counter.
// ----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int unsigned CLS_R     = 0;
    localparam int unsigned CLS_I     = 1;
    localparam int unsigned CLS_LOAD  = 2;
    localparam int unsigned CLS_STORE = 3;

    localparam logic [31:0] INS_ADD  = 32'h002081B3;
    localparam logic [31:0] INS_SRA  = 32'h4020D1B3;
    localparam logic [31:0] INS_SRAI = 32'h4000D093;
    localparam logic [31:0] INS_LW   = 32'h0040A103;
    localparam logic [31:0] INS_SW   = 32'h0020A223;
    localparam logic [31:0] INS_BAD0 = 32'hFFFFFFFF;
    localparam logic [31:0] INS_BAD1 = 32'h020000B3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req;
    logic        ir_write_enable;
    logic        dmem_req;
    logic        dmem_we;
    logic [2:0]  dmem_size;
    logic [4:0]  alu_op;
    logic        sel_b;
    logic        wb_sel;
    logic        regfile_write_enable;
    logic        pc_write_enable;
    logic        illegal_instr;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retired_count;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_retired = '0;

    always #5 clk = ~clk;

    multicycle_controller #(
        .INSTR_WIDTH  (32),
        .ALU_OP_WIDTH (5)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .instruction          (instruction),
        .imem_req             (imem_req),
        .imem_ack             (imem_ack),
        .ir_write_enable      (ir_write_enable),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_size            (dmem_size),
        .dmem_ack             (dmem_ack),
        .alu_op               (alu_op),
        .sel_b                (sel_b),
        .wb_sel               (wb_sel),
        .regfile_write_enable (regfile_write_enable),
        .pc_write_enable      (pc_write_enable),
        .illegal_instr        (illegal_instr)
`ifdef CTRL_RETIRE_CNT_EN
        ,
        .retired_count        (retired_count)
`endif
    );

    // ---------------- reference model: legal encoding table ----------------
    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        bit          f3_care;
        logic [6:0]  f7;
        bit          f7_care;
        int unsigned alu;
        int unsigned cls;
    } enc_t;

    enc_t tbl[$];

    function automatic void add_enc(input logic [6:0] opc, input logic [2:0] f3,
                                    input bit f3c, input logic [6:0] f7, input bit f7c,
                                    input int unsigned alu, input int unsigned cls);
        enc_t e;
        e.opc = opc; e.f3 = f3; e.f3_care = f3c;
        e.f7 = f7; e.f7_care = f7c; e.alu = alu; e.cls = cls;
        tbl.push_back(e);
    endfunction

    function automatic void build_table();
        // R-type: add sub sll slt sltu xor srl sra or and
        add_enc(7'h33, 3'd0, 1, 7'h00, 1, 0, CLS_R);
        add_enc(7'h33, 3'd0, 1, 7'h20, 1, 1, CLS_R);
        add_enc(7'h33, 3'd1, 1, 7'h00, 1, 2, CLS_R);
        add_enc(7'h33, 3'd2, 1, 7'h00, 1, 3, CLS_R);
        add_enc(7'h33, 3'd3, 1, 7'h00, 1, 4, CLS_R);
        add_enc(7'h33, 3'd4, 1, 7'h00, 1, 5, CLS_R);
        add_enc(7'h33, 3'd5, 1, 7'h00, 1, 6, CLS_R);
        add_enc(7'h33, 3'd5, 1, 7'h20, 1, 7, CLS_R);
        add_enc(7'h33, 3'd6, 1, 7'h00, 1, 8, CLS_R);
        add_enc(7'h33, 3'd7, 1, 7'h00, 1, 9, CLS_R);
        // I-ALU: immediate bits free except on shifts
        add_enc(7'h13, 3'd0, 1, 7'h00, 0, 0, CLS_I);
        add_enc(7'h13, 3'd2, 1, 7'h00, 0, 3, CLS_I);
        add_enc(7'h13, 3'd3, 1, 7'h00, 0, 4, CLS_I);
        add_enc(7'h13, 3'd4, 1, 7'h00, 0, 5, CLS_I);
        add_enc(7'h13, 3'd6, 1, 7'h00, 0, 8, CLS_I);
        add_enc(7'h13, 3'd7, 1, 7'h00, 0, 9, CLS_I);
        add_enc(7'h13, 3'd1, 1, 7'h00, 1, 2, CLS_I);
        add_enc(7'h13, 3'd5, 1, 7'h00, 1, 6, CLS_I);
        add_enc(7'h13, 3'd5, 1, 7'h20, 1, 7, CLS_I);
        // loads and stores of any size
        add_enc(7'h03, 3'd0, 0, 7'h00, 0, 0, CLS_LOAD);
        add_enc(7'h23, 3'd0, 0, 7'h00, 0, 0, CLS_STORE);
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output bit legal,
                                       output int unsigned cls, output int unsigned alu);
        legal = 1'b0; cls = 0; alu = 0;
        foreach (tbl[i]) begin
            if (ins[6:0] == tbl[i].opc &&
                (!tbl[i].f3_care || ins[14:12] == tbl[i].f3) &&
                (!tbl[i].f7_care || ins[31:25] == tbl[i].f7)) begin
                legal = 1'b1; cls = tbl[i].cls; alu = tbl[i].alu;
            end
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        int unsigned k;
        ins = $urandom;
        if ($urandom_range(0, 9) < 7) begin
            k = $urandom_range(0, tbl.size() - 1);
            ins[6:0] = tbl[k].opc;
            if (tbl[k].f3_care) ins[14:12] = tbl[k].f3;
            if (tbl[k].f7_care) ins[31:25] = tbl[k].f7;
        end
        return ins;
    endfunction

    function automatic logic spur();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // ---------------- checking and cycle helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_strobes(input string tag, input bit ireq, input bit irwe,
                                 input bit dreq, input bit rfwe, input bit pcwe, input bit ill);
        check_eq({tag, "/strobes{ireq,irwe,dreq,rfwe,pcwe,ill}"},
                 {26'd0, imem_req, ir_write_enable, dmem_req, regfile_write_enable,
                  pc_write_enable, illegal_instr},
                 {26'd0, ireq, irwe, dreq, rfwe, pcwe, ill});
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        sample();
        check_strobes("reset", 0, 0, 0, 0, 0, 0);
        check_eq("reset/ctrl{alu_op,sel_b,wb_sel,we,size}",
                 {21'd0, alu_op, sel_b, wb_sel, dmem_we, dmem_size}, '0);
`ifdef CTRL_RETIRE_CNT_EN
        check_eq("reset/retired_count", retired_count, '0);
`endif
        advance();
        rst = 1'b0;
        exp_retired = '0;
    endtask

    // One full instruction: wf fetch wait cycles, wm data wait cycles.
    task automatic run_instr(input logic [31:0] ins, input int unsigned wf, input int unsigned wm);
        bit          legal;
        int unsigned cls, alu, lat, cyc, seen;
        bit          is_load, is_store, is_mem;
        ref_decode(ins, legal, cls, alu);
        is_load  = legal && cls == CLS_LOAD;
        is_store = legal && cls == CLS_STORE;
        is_mem   = is_load || is_store;
        lat = wf + 4 + (is_mem ? wm : 0) + (is_load ? 1 : 0);
        cyc = 0;
        seen = 0;
        instruction = ins;

        for (int unsigned k = 0; k <= wf; k++) begin
            imem_ack = (k == wf);
            dmem_ack = spur();
            sample(); cyc++;
            check_strobes("fetch", 1, k == wf, 0, 0, 0, 0);
            advance();
        end

        imem_ack = spur(); dmem_ack = spur();
        sample(); cyc++;
        check_strobes("decode", 0, 0, 0, 0, 0, 0);
        advance();

        if (!legal) begin
            for (int unsigned k = 0; k < 3; k++) begin
                imem_ack = spur(); dmem_ack = spur();
                sample();
                check_strobes("trap", 0, 0, 0, 0, 0, 1);
                advance();
            end
            do_reset();
            return;
        end

        imem_ack = spur(); dmem_ack = spur();
        sample(); cyc++;
        check_strobes("execute", 0, 0, 0, 0, 0, 0);
        check_eq("execute/alu_op", alu_op, alu);
        check_eq("execute/sel_b", sel_b, cls != CLS_R);
        check_eq("execute/wb_sel", wb_sel, is_load);
        check_eq("execute/dmem_we", dmem_we, is_store);
        advance();

        if (is_mem) begin
            for (int unsigned k = 0; k <= wm; k++) begin
                dmem_ack = (k == wm);
                imem_ack = spur();
                sample(); cyc++;
                if (pc_write_enable && seen == 0) seen = cyc;
                check_strobes("mem", 0, 0, 1, 0, is_store && k == wm, 0);
                check_eq("mem/dmem_size", dmem_size, ins[14:12]);
                check_eq("mem/dmem_we", dmem_we, is_store);
                advance();
            end
        end

        if (!is_store) begin
            imem_ack = spur(); dmem_ack = spur();
            sample(); cyc++;
            if (pc_write_enable && seen == 0) seen = cyc;
            check_strobes("wb", 0, 0, 0, 1, 1, 0);
            check_eq("wb/wb_sel", wb_sel, is_load);
            check_eq("wb/alu_op", alu_op, alu);
            advance();
        end

        check_eq("retire_latency", seen, lat);
        exp_retired = exp_retired + 32'd1;
`ifdef CTRL_RETIRE_CNT_EN
        check_eq("retired_count", retired_count, exp_retired);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        build_table();
        @(posedge clk);
        #1;
        do_reset();

        run_instr(INS_ADD,  0, 0);
        run_instr(INS_SRA,  0, 0);
        run_instr(INS_SRAI, 1, 0);
        run_instr(INS_LW,   0, 2);
        run_instr(INS_SW,   0, 1);
        run_instr(INS_SW,   2, 0);
        run_instr(INS_BAD0, 0, 0);
        run_instr(INS_BAD1, 1, 0);
        run_instr(INS_ADD,  0, 0);

        // Reset during a fetch wait must drop the request at once.
        instruction = INS_ADD;
        sample();
        check_eq("fetch_wait/imem_req", imem_req, 1);
        advance();
        rst = 1'b1;
        #1;
        check_eq("rst_in_fetch_wait/imem_req", imem_req, 0);
        sample();
        check_strobes("rst_in_fetch_wait", 0, 0, 0, 0, 0, 0);
        advance();
        rst = 1'b0;
        exp_retired = '0;
        run_instr(INS_ADD, 0, 0);

`ifdef CTRL_RETIRE_CNT_EN
        do_reset();
        for (int unsigned i = 0; i < 10; i++) run_instr(INS_ADD, 0, 0);
        check_eq("retired_count_after_10", retired_count, 32'd10);
        force dut.retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.retired_count;
        exp_retired = 32'hFFFF_FFFF;
        run_instr(INS_ADD, 0, 0);
        check_eq("retired_count_wrap", retired_count, 32'd0);
`endif

        for (int unsigned i = 0; i < 150; i++) begin
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
